// File: rtl/ran_pkg.sv
// ran_pkg: shared constants, output-mode enum and die helpers for the PRNG tile.
package ran_pkg;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] RESET_SEED = 16'hACE1;
  localparam logic [7:0] SEED_LO = 8'hE1;
  localparam logic [LFSR_W-1:0] TAPS = 16'hB400;
  typedef enum logic [1:0] {RAW_LO, DIE, RAW_HI, DIE_SEG} mode_e;
  localparam logic [6:0][7:0] SEG7 = {8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h00};
  function automatic logic [2:0] die(input logic [7:0] v);
    return 3'(v % 8'd6) + 3'd1;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with seed load and step enable.
module lfsr16
  import ran_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load,
  input  logic [7:0]        seed,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);
  logic [LFSR_W-1:0] state_q, state_d;
  logic fb;
  always_comb begin
    fb = ^(state_q & TAPS);
    state_d = !ena ? state_q : load ? {seed, SEED_LO} : step ? {state_q[14:0], fb} : state_q;
  end
  // rst_n is active-high despite its name.
  always_ff @(posedge clk)
    if (rst_n) state_q <= RESET_SEED;
    else state_q <= state_d;
  assign state = state_q;
endmodule

// File: rtl/tt_um_ran_daniel_zhu.sv
// tt_um_ran_daniel_zhu: TinyTapeout PRNG tile showing raw bits, a die roll or its 7-seg pattern.
module tt_um_ran_daniel_zhu
  import ran_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [LFSR_W-1:0] lfsr;
  logic [7:0] out_q, out_d;
  logic [2:0] d;
  mode_e mode;
  logic unused;
  lfsr16 u_lfsr (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(ui_in[1]),
    .seed(uio_in), .step(ui_in[0]), .state(lfsr)
  );
  always_comb begin
    mode = mode_e'(ui_in[3:2]);
    d = die(lfsr[7:0]);
    out_d = !ena ? out_q :
            mode == RAW_LO ? lfsr[7:0] :
            mode == DIE ? {5'b0, d} :
            mode == RAW_HI ? lfsr[15:8] : SEG7[d];
  end
  always_ff @(posedge clk)
    if (rst_n) out_q <= 8'h00;
    else out_q <= out_d;
  assign uo_out = out_q;
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
  assign unused = &{1'b0, ui_in[7:4]};
endmodule

// File: tb/tb_tt_um_ran_daniel_zhu.sv
// tb_tt_um_ran_daniel_zhu: scoreboard bench with directed vectors for the PRNG tile.
module tb_tt_um_ran_daniel_zhu;
  logic clk = 0, rst_n = 1, ena = 1;
  logic [7:0] ui_in = 0, uio_in = 0, uo_out, uio_out, uio_oe;
  int checks = 0, failures = 0, bad_die = 0;
  typedef struct {string name; logic [7:0] exp;} exp_t;
  exp_t q[$];

  tt_um_ran_daniel_zhu dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // Monitor: each pushed expectation covers the byte registered at the preceding edge.
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({uio_oe, uio_out, uo_out} !== {16'h0000, e.exp}) begin
        failures++;
        $display("FAIL %s: got oe=%h out=%h uo=%h want oe=00 out=00 uo=%h",
                 e.name, uio_oe, uio_out, uo_out, e.exp);
      end
    end

  task automatic cyc(input logic r, input logic en, input logic [7:0] ui, input logic [7:0] uio,
                     input string nm, input logic [7:0] exp, input bit chk);
    rst_n = r; ena = en; ui_in = ui; uio_in = uio;
    @(posedge clk);
    if (chk) q.push_back('{nm, exp});
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 1, 8'h00, 8'h00, "reset", 8'h00, 1);
    cyc(0, 1, 8'h00, 8'h00, "first_e1", 8'hE1, 1);
    cyc(0, 1, 8'h08, 8'h00, "mode_hi", 8'hAC, 1);
    cyc(0, 1, 8'h04, 8'h00, "die", 8'h04, 1);
    cyc(0, 1, 8'h0C, 8'h00, "seg", 8'h66, 1);
    cyc(1, 1, 8'h00, 8'h00, "reset2", 8'h00, 1);
    cyc(0, 1, 8'h01, 8'h00, "run0", 8'hE1, 1);
    cyc(0, 1, 8'h01, 8'h00, "run1", 8'hC3, 1);
    cyc(0, 1, 8'h00, 8'h00, "run2", 8'h87, 1);
    cyc(0, 1, 8'h08, 8'h00, "run_hi", 8'hB3, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 8'h0D, 8'h55, "ena_off", 8'hB3, 1);
    cyc(0, 1, 8'h08, 8'h00, "ena_hold_hi", 8'hB3, 1);
    cyc(0, 1, 8'h00, 8'h00, "ena_hold_lo", 8'h87, 1);
    cyc(0, 1, 8'h0B, 8'h12, "load_edge", 8'hB3, 1);
    cyc(0, 1, 8'h08, 8'h00, "load_hi", 8'h12, 1);
    cyc(0, 1, 8'h05, 8'h00, "load_lo_die", 8'h04, 1);
    cyc(0, 1, 8'h05, 8'h00, "step_die", 8'h04, 1);
    cyc(0, 1, 8'h0C, 8'h00, "seg3", 8'h4F, 1);
    cyc(0, 1, 8'h04, 8'h00, "die3", 8'h03, 1);
    cyc(0, 1, 8'h08, 8'h00, "step_hi", 8'h4B, 1);
    cyc(1, 1, 8'h03, 8'h77, "rst_wins", 8'h00, 1);
    cyc(0, 1, 8'h08, 8'h00, "rst_wins_hi", 8'hAC, 1);
    cyc(0, 1, 8'h02, 8'h34, "hold_load_a", 8'hE1, 1);
    cyc(0, 1, 8'h0A, 8'h56, "hold_load_b", 8'h34, 1);
    cyc(0, 1, 8'h00, 8'h00, "hold_load_lo", 8'hE1, 1);
    cyc(0, 1, 8'h08, 8'h00, "hold_load_hi", 8'h56, 1);
    cyc(1, 1, 8'h00, 8'h00, "reset3", 8'h00, 1);
    for (int i = 0; i < 65535; i++) begin
      cyc(0, 1, 8'h05, 8'h00, "", 8'h00, 0);
      if (uo_out < 8'd1 || uo_out > 8'd6) bad_die++;
    end
    checks++;
    if (bad_die != 0) begin
      failures++;
      $display("FAIL die_range: got %0d out-of-range rolls want 0", bad_die);
    end
    cyc(0, 1, 8'h00, 8'h00, "period_lo", 8'hE1, 1);
    cyc(0, 1, 8'h08, 8'h00, "period_hi", 8'hAC, 1);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_ran_daniel_zhu.md
# tt_um_ran_daniel_zhu

Pseudo-random number generator tile for the TinyTapeout harness. A 16-bit maximal-length Fibonacci LFSR is stepped under pin control and can be seeded from the bidirectional pins. One registered output byte shows either the raw random bits, a fair-ish die roll (1–6), or that die roll as a 7-segment pattern. The block is the top level of the tile; the harness drives all pins.

## Interface
Parameters: none; constants live in the package.
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset: synchronous, active-high (asserted when rst_n=1); port name kept per harness convention
- ena  in  1  tile enable; 0 freezes all registers except reset
- ui_in  in  8  [0]=run (step LFSR), [1]=load seed, [3:2]=output mode, [7:4]=unused
- uio_in  in  8  seed byte, sampled on load
- uo_out  out  8  registered result byte
- uio_out  out  8  constant 0x00
- uio_oe  out  8  constant 0x00 (all uio pins inputs)

## Operation
- State: 16-bit `lfsr`, 8-bit `out_q` (drives uo_out).
- Feedback: fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]; step: lfsr <= {lfsr[14:0], fb}. Period 65535; all-zero state never reachable.
- Priority per edge (when ena=1): reset > load > run > hold.
  - load (ui_in[1]=1): lfsr <= {uio_in, 8'hE1}; low byte nonzero, so lockup impossible. Run ignored that cycle.
  - run (ui_in[0]=1, load=0): one step per cycle.
- Die value d = (lfsr[7:0] mod 6) + 1, range 1..6, 8-bit unsigned arithmetic.
- Output mode ui_in[3:2], out_q <= f(current lfsr):
  - 00: lfsr[7:0]
  - 01: {5'b0, d}
  - 10: lfsr[15:8]
  - 11: 7-seg of d, bit order {dp,g,f,e,d,c,b,a}, active-high, dp=0: 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D
- ena=0: lfsr and out_q hold regardless of ui_in.

## Timing
- Reset (rst_n=1 at an edge): lfsr=0xACE1, out_q=0x00; uio_out/uio_oe always 0x00.
- out_q samples the pre-edge lfsr, so uo_out lags lfsr by one cycle: step at edge k visible on uo_out after edge k+1.
- First edge after reset release (mode 00, run=0): uo_out=0xE1.
- Load at edge k: seeded value appears on uo_out after edge k+1.
- Mode change takes effect at the next edge; no other latency.
- Reset mid-run or with load/run asserted: reset wins, same reset values.
- Load held high continuously: lfsr re-seeds every cycle (no stepping).

## Structure
- Package `ran_pkg`: LFSR_W=16, RESET_SEED=16'hACE1, SEED_LO=8'hE1, tap constants, mode enum (RAW_LO, DIE, RAW_HI, DIE_SEG), 7-seg constant array.
- Sub-module `lfsr16`: clk, rst_n, ena, load, seed, step → state[15:0]. Top holds die/mod-6, mux, out_q, constant uio drives.

## Test plan
- Reset then mode 00, run=0, ena=1 → uo_out=0xE1 after one edge; mode 10 → 0xAC; uio_oe=0x00, uio_out=0x00.
- From reset, run=1 for 2 cycles → lfsr 0x59C3 then 0xB387; mode 00 uo_out shows 0xC3 then 0x87 (one-cycle lag).
- Reset, mode 01 → uo_out=0x04; mode 11 → uo_out=0x66.
- uio_in=0x12, load=1 and run=1 one cycle, mode 10 → uo_out=0x12 next edge; lfsr=0x12E1, not stepped.
- ena=0 with run=1 for 10 cycles → uo_out and lfsr unchanged; reset asserted during run → lfsr=0xACE1, uo_out=0x00.
- Free-run 65535 steps from 0xACE1 → returns to 0xACE1, never 0x0000; die values only 1..6.
